// File: rtl/store_pack_pkg.sv
// rtl/store_pack_pkg.sv - shared size encodings, lane masks, FSM states and queue entry type
package store_pack_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    localparam logic [3:0] MASK_BYTE = 4'b0001;
    localparam logic [3:0] MASK_HALF = 4'b0011;
    localparam logic [3:0] MASK_WORD = 4'b1111;

    typedef enum logic {
        ST_FIRST  = 1'b0,
        ST_SECOND = 1'b1
    } state_e;

    // Queued request, kept raw; lane packing happens at the queue head.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  size;
    } entry_t;

    function automatic logic [3:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_BYTE: size_mask = MASK_BYTE;
            SZ_HALF: size_mask = MASK_HALF;
            default: size_mask = MASK_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        is_misaligned = ((size == SZ_HALF) && off[0]) ||
                        ((size == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/store_pack_fifo.sv
// rtl/store_pack_fifo.sv - power-of-two store request queue with push/pop/full/empty
module store_pack_fifo
    import store_pack_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t wdata,
    input  logic   pop,
    output entry_t rdata,
    output logic   full,
    output logic   empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     count;
    logic            push_ok;
    logic            pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rptr];

    // Pointers wrap naturally because DEPTH is a power of two; push+pop keeps count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset; empty gates every use of the head.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/store_pack.sv
// rtl/store_pack.sv - store lane packer with queue and write-beat FSM; option STORE_PACK_SPLIT_EN
module store_pack
    import store_pack_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [1:0]  req_size,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        err_valid,
    output logic [31:0] err_addr,
    output logic        busy
);

    logic        ready_en;
    logic        fifo_full;
    logic        fifo_empty;
    logic        accept;
    logic        legal;
    logic        push;
    logic        pop;
    logic        in_second;
    logic        head_split;
    entry_t      head;
    entry_t      new_entry;
    logic [1:0]  off;
    logic [31:0] base;
    logic [7:0]  wide_be;
    logic [63:0] wide_data;
    logic [31:0] repl_data;

    // req_ready depends only on registered state, never on mem_ready.
    assign req_ready = ready_en && !fifo_full;
    assign accept    = req_valid && req_ready;

`ifdef STORE_PACK_SPLIT_EN
    assign legal = (req_size != SZ_RSVD);
`else
    assign legal = (req_size != SZ_RSVD) && !is_misaligned(req_size, req_addr[1:0]);
`endif

    assign push      = accept && legal;
    assign new_entry = '{addr: req_addr, data: req_data, size: req_size};

    // Hold req_ready low through reset and raise it on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en <= 1'b0;
        else        ready_en <= 1'b1;
    end

    // One-cycle error pulse for dropped requests; the address is held until the next error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
        end else begin
            err_valid <= accept && !legal;
            if (accept && !legal) err_addr <= req_addr;
        end
    end

    store_pack_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (new_entry),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign mem_valid = !fifo_empty;
    assign busy      = !fifo_empty;

    // Lane geometry of the head entry; the upper halves feed the second beat of a split.
    assign off       = head.addr[1:0];
    assign base      = {head.addr[31:2], 2'b00};
    assign wide_be   = {4'b0000, size_mask(head.size)} << off;
    assign wide_data = {32'h0, head.data} << {off, 3'b000};

`ifdef STORE_PACK_SPLIT_EN
    state_e state;
    state_e next_state;

    assign head_split = is_misaligned(head.size, off);
    assign in_second  = (state == ST_SECOND);

    // Beat FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FIRST;
        else        state <= next_state;
    end

    // Advance to SECOND after the first half of a split entry, back to FIRST on its pop.
    always_comb begin
        next_state = state;
        if (mem_valid && mem_ready) begin
            case (state)
                ST_FIRST:  if (head_split) next_state = ST_SECOND;
                ST_SECOND: next_state = ST_FIRST;
                default:   next_state = ST_FIRST;
            endcase
        end
    end
`else
    // Misaligned requests never enter the queue, so only FIRST exists.
    assign head_split = 1'b0;
    assign in_second  = 1'b0;
`endif

    // Replicate narrow data across lanes for single-beat stores.
    always_comb begin
        repl_data = head.data;
        case (head.size)
            SZ_BYTE: repl_data = {4{head.data[7:0]}};
            SZ_HALF: repl_data = {2{head.data[15:0]}};
            default: repl_data = head.data;
        endcase
    end

    // Drive the beat from the queue head (stable until handshake) and pop on its last beat.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        pop       = 1'b0;
        if (mem_valid) begin
            if (in_second) begin
                mem_addr  = base + 32'd4;
                mem_wdata = wide_data[63:32];
                mem_be    = wide_be[7:4];
                pop       = mem_ready;
            end else begin
                mem_addr  = base;
                mem_wdata = head_split ? wide_data[31:0] : repl_data;
                mem_be    = wide_be[3:0];
                pop       = mem_ready && !head_split;
            end
        end
    end

endmodule
